// File: rtl/nco_sweep_ctrl.sv
// nco_sweep_ctrl: frequency-sweep scheduler driving the increment of an NCO.
// It accepts one sweep descriptor per handshake and steps the increment through
// a linear ramp, holding each frequency for dwell+1 clocks. It supports
// one-shot and loop modes and can be aborted at any time.
// Optional macro NCO_SWEEP_BIDIR_EN: loop mode becomes a triangular sweep
// (the ramp retraces to start) instead of a sawtooth.
module nco_sweep_ctrl #(
    parameter int INC_W   = 23,
    parameter int CNT_W   = 12,
    parameter int DWELL_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [INC_W-1:0]   cfg_start,
    input  logic [INC_W-1:0]   cfg_step,
    input  logic [CNT_W-1:0]   cfg_count,
    input  logic [DWELL_W-1:0] cfg_dwell,
    input  logic               cfg_loop,
    input  logic               abort,
    output logic [INC_W-1:0]   inc,
    output logic               inc_stb,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_r, state_nxt;
    logic [INC_W-1:0]   inc_r, inc_nxt;
    logic               stb_r, stb_nxt;
    logic               busy_r, busy_nxt;
    logic               done_r, done_nxt;
    logic [DWELL_W-1:0] dwell_cnt_r, dwell_cnt_nxt;
    logic [CNT_W-1:0]   step_cnt_r, step_cnt_nxt;
    logic [INC_W-1:0]   start_r, start_nxt;
    logic [INC_W-1:0]   step_r, step_nxt;
    logic [CNT_W-1:0]   count_r, count_nxt;
    logic [DWELL_W-1:0] dwell_r, dwell_nxt;
    logic               loop_r, loop_nxt;
`ifdef NCO_SWEEP_BIDIR_EN
    // High while the triangular sweep is retracing toward the start value.
    logic               dir_r, dir_nxt;
`endif

    // A new descriptor can only be taken while idle and not being aborted.
    assign cfg_ready = (state_r == IDLE) & ~abort;

    assign inc     = inc_r;
    assign inc_stb = stb_r;
    assign busy    = busy_r;
    assign done    = done_r;

    // Next-state and next-output logic for the sweep sequencer.
    always_comb begin
        state_nxt     = state_r;
        inc_nxt       = inc_r;
        stb_nxt       = 1'b0;
        busy_nxt      = busy_r;
        done_nxt      = 1'b0;
        dwell_cnt_nxt = dwell_cnt_r;
        step_cnt_nxt  = step_cnt_r;
        start_nxt     = start_r;
        step_nxt      = step_r;
        count_nxt     = count_r;
        dwell_nxt     = dwell_r;
        loop_nxt      = loop_r;
`ifdef NCO_SWEEP_BIDIR_EN
        dir_nxt       = dir_r;
`endif
        case (state_r)
            IDLE: begin
                busy_nxt = 1'b0;
                if (cfg_valid && cfg_ready) begin
                    start_nxt     = cfg_start;
                    step_nxt      = cfg_step;
                    count_nxt     = cfg_count;
                    dwell_nxt     = cfg_dwell;
                    loop_nxt      = cfg_loop;
                    state_nxt     = RUN;
                    inc_nxt       = cfg_start;
                    stb_nxt       = 1'b1;
                    busy_nxt      = 1'b1;
                    dwell_cnt_nxt = cfg_dwell;
                    step_cnt_nxt  = cfg_count;
`ifdef NCO_SWEEP_BIDIR_EN
                    dir_nxt       = 1'b0;
`endif
                end else begin
                    state_nxt = IDLE;
                end
            end
            RUN: begin
                if (abort) begin
                    // Abort wins over every ramp transition and mutes the NCO.
                    state_nxt = IDLE;
                    inc_nxt   = {INC_W{1'b0}};
                    stb_nxt   = 1'b1;
                    busy_nxt  = 1'b0;
                end else if (dwell_cnt_r != {DWELL_W{1'b0}}) begin
                    dwell_cnt_nxt = dwell_cnt_r - {{(DWELL_W-1){1'b0}}, 1'b1};
                end else if (step_cnt_r != {CNT_W{1'b0}}) begin
`ifdef NCO_SWEEP_BIDIR_EN
                    inc_nxt = dir_r ? (inc_r - step_r) : (inc_r + step_r);
`else
                    inc_nxt = inc_r + step_r;
`endif
                    stb_nxt       = (inc_nxt != inc_r);
                    step_cnt_nxt  = step_cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                    dwell_cnt_nxt = dwell_r;
                end else if (!loop_r) begin
                    // One-shot finished: final increment keeps playing.
                    state_nxt = DONE;
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                end else begin
                    dwell_cnt_nxt = dwell_r;
`ifdef NCO_SWEEP_BIDIR_EN
                    // The turnaround itself is the first step of the new leg.
                    if (count_r == {CNT_W{1'b0}}) begin
                        step_cnt_nxt = {CNT_W{1'b0}};
                    end else begin
                        dir_nxt      = ~dir_r;
                        inc_nxt      = dir_r ? (inc_r + step_r) : (inc_r - step_r);
                        step_cnt_nxt = count_r - {{(CNT_W-1){1'b0}}, 1'b1};
                    end
`else
                    inc_nxt      = start_r;
                    step_cnt_nxt = count_r;
`endif
                    stb_nxt = (inc_nxt != inc_r);
                end
            end
            DONE: begin
                state_nxt = IDLE;
                busy_nxt  = 1'b0;
                if (abort) begin
                    inc_nxt = {INC_W{1'b0}};
                    stb_nxt = 1'b1;
                end else begin
                    inc_nxt = inc_r;
                end
            end
            default: begin
                state_nxt = IDLE;
                inc_nxt   = {INC_W{1'b0}};
                busy_nxt  = 1'b0;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            inc_r       <= {INC_W{1'b0}};
            stb_r       <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            dwell_cnt_r <= {DWELL_W{1'b0}};
            step_cnt_r  <= {CNT_W{1'b0}};
            start_r     <= {INC_W{1'b0}};
            step_r      <= {INC_W{1'b0}};
            count_r     <= {CNT_W{1'b0}};
            dwell_r     <= {DWELL_W{1'b0}};
            loop_r      <= 1'b0;
`ifdef NCO_SWEEP_BIDIR_EN
            dir_r       <= 1'b0;
`endif
        end else begin
            state_r     <= state_nxt;
            inc_r       <= inc_nxt;
            stb_r       <= stb_nxt;
            busy_r      <= busy_nxt;
            done_r      <= done_nxt;
            dwell_cnt_r <= dwell_cnt_nxt;
            step_cnt_r  <= step_cnt_nxt;
            start_r     <= start_nxt;
            step_r      <= step_nxt;
            count_r     <= count_nxt;
            dwell_r     <= dwell_nxt;
            loop_r      <= loop_nxt;
`ifdef NCO_SWEEP_BIDIR_EN
            dir_r       <= dir_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Testbench for nco_sweep_ctrl: directed scenarios plus randomized descriptors,
// all checked cycle by cycle against a sweep model that derives the expected
// increment from elapsed time since the descriptor was accepted.
module tb_nco_sweep_ctrl;
    localparam int INC_W   = 23;
    localparam int CNT_W   = 12;
    localparam int DWELL_W = 16;

    logic               clk = 1'b0;
    logic               rst;
    logic               cfg_valid;
    logic               cfg_ready;
    logic [INC_W-1:0]   cfg_start;
    logic [INC_W-1:0]   cfg_step;
    logic [CNT_W-1:0]   cfg_count;
    logic [DWELL_W-1:0] cfg_dwell;
    logic               cfg_loop;
    logic               abort;
    logic [INC_W-1:0]   inc;
    logic               inc_stb;
    logic               busy;
    logic               done;

    nco_sweep_ctrl #(.INC_W(INC_W), .CNT_W(CNT_W), .DWELL_W(DWELL_W)) dut (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_start(cfg_start), .cfg_step(cfg_step), .cfg_count(cfg_count),
        .cfg_dwell(cfg_dwell), .cfg_loop(cfg_loop), .abort(abort),
        .inc(inc), .inc_stb(inc_stb), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: phase 0 = idle, 1 = sweeping, 2 = one-shot completion cycle.
    int               m_phase;
    int               m_t;
    logic [INC_W-1:0] m_inc;
    logic             m_stb, m_busy, m_done;
    logic [INC_W-1:0] l_start, l_step;
    int               l_count, l_dwell;
    logic             l_loop;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Increment that should be playing t cycles after the descriptor was taken.
    function automatic logic [INC_W-1:0] value_at(input int t);
        int idx;
        int p;
        longint v;
        p = t / (l_dwell + 1);
        if (!l_loop) begin
            idx = p;
        end else begin
`ifdef NCO_SWEEP_BIDIR_EN
            if (l_count == 0) idx = 0;
            else begin
                idx = p % (2 * l_count);
                if (idx > l_count) idx = 2 * l_count - idx;
            end
`else
            idx = p % (l_count + 1);
`endif
        end
        v = longint'(l_start) + longint'(idx) * longint'(l_step);
        return v[INC_W-1:0];
    endfunction

    task automatic check_outputs();
        check_val("inc", 32'(inc), 32'(m_inc));
        check_val("inc_stb", 32'(inc_stb), 32'(m_stb));
        check_val("busy", 32'(busy), 32'(m_busy));
        check_val("done", 32'(done), 32'(m_done));
    endtask

    // One clock: apply inputs, check cfg_ready, advance the model, check outputs.
    task automatic cyc(input logic v, input logic ab, input logic r);
        logic [INC_W-1:0] nv;
        cfg_valid = v;
        abort     = ab;
        rst       = r;
        #1;
        check_val("cfg_ready", 32'(cfg_ready), 32'((m_phase == 0) && !ab));
        @(posedge clk);
        #1;
        m_stb  = 1'b0;
        m_done = 1'b0;
        if (r) begin
            m_phase = 0; m_inc = '0; m_busy = 1'b0;
        end else if (ab && m_phase != 0) begin
            m_phase = 0; m_inc = '0; m_stb = 1'b1; m_busy = 1'b0;
        end else if (m_phase == 0) begin
            if (v && !ab) begin
                l_start = cfg_start; l_step = cfg_step; l_count = int'(cfg_count);
                l_dwell = int'(cfg_dwell); l_loop = cfg_loop;
                m_phase = 1; m_t = 0; m_inc = cfg_start; m_stb = 1'b1; m_busy = 1'b1;
            end
        end else if (m_phase == 1) begin
            m_t++;
            if (!l_loop && (m_t / (l_dwell + 1)) > l_count) begin
                m_phase = 2; m_busy = 1'b0; m_done = 1'b1;
            end else begin
                nv    = value_at(m_t);
                m_stb = ((m_t % (l_dwell + 1)) == 0) && (nv != m_inc);
                m_inc = nv;
            end
        end else begin
            m_phase = 0;
        end
        check_outputs();
    endtask

    task automatic set_desc(input logic [INC_W-1:0] s, input logic [INC_W-1:0] st,
                            input int c, input int d, input logic lp);
        cfg_start = s; cfg_step = st; cfg_count = CNT_W'(c);
        cfg_dwell = DWELL_W'(d); cfg_loop = lp;
    endtask

    initial begin
        rst = 1'b1; cfg_valid = 1'b0; abort = 1'b0;
        set_desc(23'd0, 23'd0, 0, 0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        m_phase = 0; m_inc = '0; m_stb = 1'b0; m_busy = 1'b0; m_done = 1'b0; m_t = 0;
        check_outputs();
        cyc(1'b0, 1'b0, 1'b0);

        // One-shot ramp 2237..2537, three cycles per frequency.
        set_desc(23'd2237, 23'd100, 3, 2, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        repeat (16) cyc(1'b0, 1'b0, 1'b0);
        check_val("final_inc", 32'(inc), 32'd2537);

        // Descending sawtooth loop, one cycle per frequency, then abort.
        set_desc(23'd2237, 23'h7FFF9C, 2, 0, 1'b1);
        cyc(1'b1, 1'b0, 1'b0);
        repeat (11) cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        check_val("abort_inc", 32'(inc), 32'd0);
        repeat (2) cyc(1'b0, 1'b0, 1'b0);

        // Increment wraps modulo 2^23.
        set_desc(23'h7FFFF0, 23'h000020, 1, 0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        check_val("wrap_inc", 32'(inc), 32'h10);
        repeat (3) cyc(1'b0, 1'b0, 1'b0);

        // cfg_valid held high with changing fields during a sweep.
        set_desc(23'd500, 23'd7, 2, 1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        set_desc(23'd9999, 23'd3, 1, 0, 1'b0);
        repeat (12) cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);

        // Single frequency in loop mode: one strobe only.
        set_desc(23'd4242, 23'd5, 0, 1, 1'b1);
        cyc(1'b1, 1'b0, 1'b0);
        repeat (7) cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);

        // Reset in the middle of a sweep.
        set_desc(23'd300, 23'd11, 4, 2, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        repeat (5) cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1);
        check_val("rst_done", 32'(done), 32'd0);
        cyc(1'b0, 1'b0, 1'b0);

        // Abort coincident with the final dwell cycle of a one-shot.
        set_desc(23'd800, 23'd50, 1, 2, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        repeat (5) cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        check_val("abort_last_done", 32'(done), 32'd0);
        repeat (2) cyc(1'b0, 1'b0, 1'b0);

`ifdef NCO_SWEEP_BIDIR_EN
        // Triangular loop sweep.
        set_desc(23'd1000, 23'd10, 2, 0, 1'b1);
        cyc(1'b1, 1'b0, 1'b0);
        repeat (10) cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
`endif

        // Randomized descriptors, fields churning, sporadic abort and reset.
        for (int k = 0; k < 60; k++) begin
            int ncyc;
            ncyc = int'($urandom_range(40, 5));
            for (int j = 0; j < ncyc; j++) begin
                set_desc(23'($urandom), 23'($urandom), int'($urandom_range(4, 0)),
                         int'($urandom_range(3, 0)), 1'($urandom));
                cyc(1'($urandom), ($urandom_range(15, 0) == 0), ($urandom_range(63, 0) == 0));
            end
        end
        repeat (30) cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/nco_sweep_ctrl.md
Name: nco_sweep_ctrl

Overview:
Frequency-sweep scheduler that drives the increment input of an `nco` instance, whose phase output feeds `sincos`.
- Accepts one sweep descriptor per handshake: start increment, signed step, step count, dwell, mode.
- Steps the NCO increment through the programmed ramp with a fixed dwell per frequency.
- Used for chirp/stepped-tone generation and receiver calibration sweeps, in place of a constant increment.

Parameters:
INC_W, 23, width of NCO increment word (matches NCO accumulator width PHASE)
CNT_W, 12, width of step-count field
DWELL_W, 16, width of dwell field

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous active-high reset
cfg_valid  in  1  descriptor present
cfg_ready  out  1  controller can accept descriptor
cfg_start  in  INC_W  first increment
cfg_step  in  INC_W  per-step increment delta, two's complement
cfg_count  in  CNT_W  number of steps after start (frequencies = count+1)
cfg_dwell  in  DWELL_W  hold per frequency = dwell+1 clocks
cfg_loop  in  1  0 = one-shot, 1 = repeat until abort
abort  in  1  stop sweep
inc  out  INC_W  increment to NCO
inc_stb  out  1  one-cycle pulse each time inc changes value
busy  out  1  sweep in progress
done  out  1  one-cycle pulse at one-shot completion

Behaviour:
- Reset values: inc=0, inc_stb=0, busy=0, done=0, state=IDLE, cfg_ready=1 from the first cycle after reset.
- States: IDLE, RUN, DONE.
- cfg_ready = (state==IDLE) & ~abort. It is combinational from the registered state.
- Descriptor handshake: fields are latched on the edge where cfg_valid & cfg_ready.
  - On the next cycle: state=RUN, inc=cfg_start, inc_stb=1, busy=1.
  - dwell counter = cfg_dwell; step counter = cfg_count.
- RUN:
  - The dwell counter decrements each clock.
  - When dwell==0 and steps>0: inc <= inc + step (modulo 2^INC_W, wrap silently), inc_stb=1, steps--, dwell reloads.
  - Each frequency is therefore held exactly dwell+1 cycles.
- End of ramp (dwell==0, steps==0):
  - cfg_loop=0: go to DONE. inc holds its final value, busy=0, done=1 for that one cycle, then IDLE.
  - cfg_loop=1: inc <= latched start, inc_stb=1, counters reload, stay in RUN.
- cfg_count=0: single frequency held dwell+1 cycles, then done. With loop=1, inc stays constant and inc_stb pulses only at the first load.
- abort (any state except IDLE): next cycle state=IDLE, inc=0 (mutes NCO), inc_stb=1, busy=0, done=0.
- abort in IDLE: no effect apart from blocking the handshake.
- abort has priority over the end-of-ramp transition in the same cycle.
- cfg_valid while busy is ignored; the descriptor is not accepted until IDLE.
- rst mid-sweep: all state returns to reset values on that edge. No done pulse.
- inc is registered; the NCO sees a new value one cycle after inc_stb rises.

Optional Feature:
Macro NCO_SWEEP_BIDIR_EN.
- Defined: in loop mode, the sweep is triangular. At end of ramp the step sign is negated internally (inc <= inc - step) and counters reload, so the ramp retraces to start, then reverses again. One-shot behaviour is unchanged.
- Not defined: loop mode is sawtooth (jump back to start). No direction register is synthesised.

Test Plan:
1. start=2237, step=100, count=3, dwell=2, loop=0 -> inc = 2237,2337,2437,2537, each for 3 cycles; 4 inc_stb pulses; done high 1 cycle after the last 2537 cycle; inc stays 2537; busy low, cfg_ready high after.
2. start=2237, step=-100 (0x7FFF9C), count=2, dwell=0, loop=1 -> inc = 2237,2137,2037,2237,2137... every cycle; done never asserts. Then abort -> inc=0 next cycle, busy=0.
3. Wrap: start=0x7FFFF0, step=0x20, count=1, dwell=0 -> inc = 0x7FFFF0 then 0x000010; done after.
4. cfg_valid held high during a sweep with different fields -> ignored until IDLE, then accepted exactly once per cfg_ready&cfg_valid.
5. rst asserted mid-RUN, and abort coincident with the last dwell cycle -> reset values on next cycle; no done pulse in either case.
6. With NCO_SWEEP_BIDIR_EN: start=1000, step=10, count=2, dwell=0, loop=1 -> inc = 1000,1010,1020,1010,1000,1010,1020...
